// File: rtl/mm_arbiter.sv
// Round-robin two-port arbiter for a line-wide main memory, one transaction in flight, watchdog abort.
// Read done 2+L cycles after the request is sampled; level-held requests simply wait while a transaction is busy.
module mm_arbiter #(
  parameter int LINE_W  = 256,
  parameter int MM_A_W  = 27,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       r0_a,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [LINE_W-1:0] r0_wd,
  output logic [LINE_W-1:0] r0_rd,
  output logic              r0_done,
  input  logic [31:0]       r1_a,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [LINE_W-1:0] r1_wd,
  output logic [LINE_W-1:0] r1_rd,
  output logic              r1_done,
  output logic [MM_A_W-1:0] mm_a,
  output logic [LINE_W-1:0] mm_wd,
  output logic              mm_read,
  output logic              mm_write,
  input  logic [LINE_W-1:0] mm_rd,
  input  logic              mm_valid,
  input  logic              mm_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_rd_q, op_rd_d;
  logic              win_q, win_d;
  logic              rr_last_q, rr_last_d;
  logic [MM_A_W-1:0] mm_a_d;
  logic [LINE_W-1:0] mm_wd_d, r0_rd_d, r1_rd_d;
  logic              mm_read_d, mm_write_d, r0_done_d, r1_done_d, timeout_err_d;
  logic [1:0]        grant_d;
  logic              req0, req1, pick, complete;

  // Only the line-address bits of the byte addresses matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{r0_a, r1_a};

  assign req0 = r0_read | r0_write;
  assign req1 = r1_read | r1_write;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_rd_d       = op_rd_q;
    win_d         = win_q;
    rr_last_d     = rr_last_q;
    mm_a_d        = mm_a;
    mm_wd_d       = mm_wd;
    grant_d       = grant;
    r0_rd_d       = r0_rd;
    r1_rd_d       = r1_rd;
    mm_read_d     = 1'b0;
    mm_write_d    = 1'b0;
    r0_done_d     = 1'b0;
    r1_done_d     = 1'b0;
    timeout_err_d = 1'b0;
    pick          = 1'b0;
    complete      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((req0 | req1) && mm_ready) begin
          // Under contention the port not granted last wins.
          pick       = (req0 & req1) ? ~rr_last_q : req1;
          win_d      = pick;
          op_rd_d    = pick ? r1_read : r0_read;
          mm_a_d     = pick ? r1_a[5 +: MM_A_W] : r0_a[5 +: MM_A_W];
          mm_wd_d    = pick ? r1_wd : r0_wd;
          grant_d    = pick ? 2'b10 : 2'b01;
          mm_read_d  = op_rd_d;
          mm_write_d = ~op_rd_d;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A write's ready in the first WAIT cycle is the stale pre-command level.
        complete = op_rd_q ? mm_valid : (mm_ready && (cnt_q != '0));
        if (complete || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          if (op_rd_q) begin
            if (win_q) r1_rd_d = complete ? mm_rd : '0;
            else       r0_rd_d = complete ? mm_rd : '0;
          end
          r0_done_d     = ~win_q;
          r1_done_d     = win_q;
          timeout_err_d = ~complete;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rr_last_d = win_q;
        grant_d   = 2'b00;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_rd_q     <= 1'b0;
      win_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      mm_a        <= '0;
      mm_wd       <= '0;
      mm_read     <= 1'b0;
      mm_write    <= 1'b0;
      grant       <= 2'b00;
      r0_rd       <= '0;
      r1_rd       <= '0;
      r0_done     <= 1'b0;
      r1_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_rd_q     <= op_rd_d;
      win_q       <= win_d;
      rr_last_q   <= rr_last_d;
      mm_a        <= mm_a_d;
      mm_wd       <= mm_wd_d;
      mm_read     <= mm_read_d;
      mm_write    <= mm_write_d;
      grant       <= grant_d;
      r0_rd       <= r0_rd_d;
      r1_rd       <= r1_rd_d;
      r0_done     <= r0_done_d;
      r1_done     <= r1_done_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter against a small line memory (read latency 4, write busy 4, optional no-valid).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_mm_arbiter;

  localparam int LINE_W = 256;
  localparam int MM_A_W = 27;
  localparam int RD_LAT = 4;
  localparam int WR_BUSY = 4;

  localparam logic [LINE_W-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_12 = {16{16'h1234}};
  localparam logic [LINE_W-1:0] LINE_5A = {32{8'h5A}};

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       r0_a, r1_a;
  logic              r0_read, r0_write, r1_read, r1_write;
  logic [LINE_W-1:0] r0_wd, r1_wd, r0_rd, r1_rd;
  logic              r0_done, r1_done;
  logic [MM_A_W-1:0] mm_a;
  logic [LINE_W-1:0] mm_wd, mm_rd;
  logic              mm_read, mm_write, mm_valid, mm_ready;
  logic [1:0]        grant;
  logic              timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  mm_arbiter #(.LINE_W(LINE_W), .MM_A_W(MM_A_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .r0_a(r0_a), .r0_read(r0_read), .r0_write(r0_write), .r0_wd(r0_wd), .r0_rd(r0_rd), .r0_done(r0_done),
    .r1_a(r1_a), .r1_read(r1_read), .r1_write(r1_write), .r1_wd(r1_wd), .r1_rd(r1_rd), .r1_done(r1_done),
    .mm_a(mm_a), .mm_wd(mm_wd), .mm_read(mm_read), .mm_write(mm_write),
    .mm_rd(mm_rd), .mm_valid(mm_valid), .mm_ready(mm_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory model: stale ready for one cycle after a write, then busy, then ready again.
  logic [LINE_W-1:0] mem [16];
  int rd_cnt = 0;
  int wr_ph = 0;
  int rd_idx = 0;
  bit no_valid = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[9] = LINE_A5;
    mm_ready = 1'b1;
    mm_valid = 1'b0;
    mm_rd = '0;
    forever begin
      @(negedge clk);
      mm_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0 && !no_valid) begin
          mm_valid = 1'b1;
          mm_rd = mem[rd_idx];
        end
      end
      if (wr_ph > 0) begin
        wr_ph++;
        if (wr_ph >= 3 + WR_BUSY) begin
          wr_ph = 0;
          mm_ready = 1'b1;
        end else begin
          mm_ready = !(wr_ph >= 3);
        end
      end
      if (mm_read) begin
        rd_cnt = RD_LAT;
        rd_idx = int'(mm_a[3:0]);
      end
      if (mm_write) begin
        mem[mm_a[3:0]] = mm_wd;
        wr_ph = 1;
      end
    end
  end

  // One request on one port; latency counted in falling edges after the IDLE cycle that sees it.
  task automatic run_req(input int port, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [LINE_W-1:0] wd, output int lat, output int nr, output int nw,
                         output logic [1:0] g1, output logic [MM_A_W-1:0] a1,
                         output logic [LINE_W-1:0] wd1, output logic te, output logic [1:0] g_after);
    lat = -1; nr = 0; nw = 0; g1 = '0; a1 = '0; wd1 = '0; te = 1'b0;
    if (port == 0) begin r0_a = a; r0_read = rd; r0_write = wr; r0_wd = wd; end
    else           begin r1_a = a; r1_read = rd; r1_write = wr; r1_wd = wd; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mm_read) nr++;
      if (mm_write) nw++;
      if (k == 1) begin g1 = grant; a1 = mm_a; wd1 = mm_wd; end
      if ((port == 0 && r0_done) || (port == 1 && r1_done)) begin
        lat = k;
        te = timeout_err;
        break;
      end
    end
    r0_read = 1'b0; r0_write = 1'b0; r1_read = 1'b0; r1_write = 1'b0;
    @(negedge clk);
    g_after = grant;
  endtask

  logic [1:0] gseq [8];
  int ng, d0, d1;

  task automatic rr_run(input int n);
    logic [1:0] prev;
    ng = 0; d0 = 0; d1 = 0; prev = 2'b00;
    for (int i = 0; i < 8; i++) gseq[i] = 2'b00;
    r0_a = 32'h120; r1_a = 32'h40;
    r0_read = 1'b1; r1_read = 1'b1;
    for (int k = 0; k < 300 && (d0 < n || d1 < n); k++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev == 2'b00 && ng < 8) begin
        gseq[ng] = grant;
        ng++;
      end
      prev = grant;
      if (r0_done) d0++;
      if (r1_done) d1++;
      r0_read = (d0 < n);
      r1_read = (d1 < n);
    end
    r0_read = 1'b0; r1_read = 1'b0;
    @(negedge clk);
  endtask

  int lat, nr, nw, dn;
  logic [1:0] g1, ga;
  logic [MM_A_W-1:0] a1;
  logic [LINE_W-1:0] wd1;
  logic te;

  initial begin
    reset = 1'b1;
    r0_a = '0; r0_read = 1'b0; r0_write = 1'b0; r0_wd = '0;
    r1_a = '0; r1_read = 1'b0; r1_write = 1'b0; r1_wd = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {grant, mm_read, mm_write, r0_done, r1_done, timeout_err}, '0);
    check("reset_data", {mm_a, r0_rd[7:0], r1_rd[7:0]}, '0);
    reset = 1'b0;

    // Single read, port 0.
    run_req(0, 1'b1, 1'b0, 32'h0000_0120, '0, lat, nr, nw, g1, a1, wd1, te, ga);
    check("rd0_lat", lat, 6);
    check("rd0_grant", g1, 2'b01);
    check("rd0_mm_a", a1, 27'h9);
    check("rd0_pulses", {nr[7:0], nw[7:0]}, {8'd1, 8'd0});
    check("rd0_data", r0_rd, LINE_A5);
    check("rd0_grant_clr", ga, 2'b00);

    // Single write, port 1, then read back.
    run_req(1, 1'b0, 1'b1, 32'h0000_0040, LINE_12, lat, nr, nw, g1, a1, wd1, te, ga);
    check("wr1_lat", lat, 8);
    check("wr1_grant", g1, 2'b10);
    check("wr1_mm_a", a1, 27'h2);
    check("wr1_mm_wd", wd1, LINE_12);
    check("wr1_pulses", {nr[7:0], nw[7:0]}, {8'd0, 8'd1});
    run_req(1, 1'b1, 1'b0, 32'h0000_0040, '0, lat, nr, nw, g1, a1, wd1, te, ga);
    check("rb1_lat", lat, 6);
    check("rb1_data", r1_rd, LINE_12);

    // Continuous contention, four transactions per port.
    rr_run(4);
    check("rr_ngrants", ng, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_grant%0d", i), gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    check("rr_done0", d0, 4);
    check("rr_done1", d1, 4);

    // Watchdog abort, then normal service.
    no_valid = 1'b1;
    run_req(0, 1'b1, 1'b0, 32'h0000_0120, '0, lat, nr, nw, g1, a1, wd1, te, ga);
    no_valid = 1'b0;
    check("to_lat", lat, 10);
    check("to_err", te, 1'b1);
    check("to_rd_zero", r0_rd, '0);
    check("to_r1_hold", r1_rd, LINE_12);
    run_req(0, 1'b1, 1'b0, 32'h0000_0120, '0, lat, nr, nw, g1, a1, wd1, te, ga);
    check("post_to_lat", lat, 6);
    check("post_to_err", te, 1'b0);
    check("post_to_data", r0_rd, LINE_A5);

    // Reset while a port-0 read sits in WAIT; the late mm_valid lands in IDLE.
    r0_a = 32'h120; r0_read = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_grant", grant, 2'b01);
    reset = 1'b1; r0_read = 1'b0;
    @(negedge clk);
    check("mid_rst_ctl", {grant, mm_read, mm_write, r0_done, r1_done, timeout_err}, '0);
    check("mid_rst_addr", mm_a, '0);
    check("mid_rst_wd", mm_wd, '0);
    check("mid_rst_rd", {r0_rd, r1_rd} == '0, 1'b1);
    reset = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (r0_done || r1_done || timeout_err) dn++;
    end
    check("mid_no_done", dn, 0);
    check("mid_late_valid_ignored", r0_rd, '0);
    rr_run(1);
    check("mid_favour0", gseq[0], 2'b01);
    check("mid_second", gseq[1], 2'b10);

    // Read and write together on port 0: read wins, memory untouched.
    run_req(0, 1'b1, 1'b1, 32'h0000_0120, LINE_5A, lat, nr, nw, g1, a1, wd1, te, ga);
    check("rw_pulses", {nr[7:0], nw[7:0]}, {8'd1, 8'd0});
    check("rw_lat", lat, 6);
    check("rw_data", r0_rd, LINE_A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule
